wallace_final_adder: RTL
========================

Name: wallace_final_adder

Overview:
- Pipelined carry-propagate adder directly downstream of the Wallace reduction tree.
- Consumes the two rows (sum vector, carry vector) left after the half/full-adder compression and produces the final product.
- Splits the addition into CHUNK-bit slices, one slice per pipeline stage, and passes the carry between stages.
- Valid/ready handshake on both sides; throughput is one result per cycle when not stalled.

Parameters:
WIDTH, 16, width of both operand rows and of the result (2N for an NxN multiplier).
CHUNK, 8, bits added per pipeline stage. WIDTH % CHUNK must be 0, otherwise elaboration fails via $error.
STAGES, WIDTH/CHUNK (localparam), pipeline depth.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream tree presents an operand pair
in_ready  output  1  block accepts the pair this cycle
in_sum  input  WIDTH  sum row from the reduction tree
in_carry  input  WIDTH  carry row, already bit-aligned (shift done by the tree)
out_valid  output  1  out_result holds a completed product
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH

Behaviour:
- Reset is asynchronous and active-high on rst, with a single clock clk.
- Reset clears all stage valid bits, all data and carry registers, out_valid=0, out_result=0. Mid-flight transactions are discarded.
- Stall rule:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0 every stage register holds.
  - Bubbles are not collapsed; the whole pipe moves or freezes together.
- Accept: in_valid && in_ready at a rising edge.
- Stage 0:
  - Adds in_sum[CHUNK-1:0] + in_carry[CHUNK-1:0] with carry-in 0.
  - Registers the CHUNK result bits and carry-out.
  - Registers the untouched upper operand bits.
- Stage s (1..STAGES-1):
  - Adds slice s of the forwarded operands plus the registered carry from stage s-1.
  - Appends its result bits to the accumulated lower result.
  - Forwards the remaining upper operand bits.
- Each stage carries a valid bit that follows the data. When advance=1 and the upstream valid is 0, a bubble (valid=0) enters. Data registers may hold stale values under valid=0.
- Latency: out_valid rises after STAGES rising edges, counting the accepting edge as the first. Default is 2 cycles.
- out_result/out_valid are the final stage registers. They stay stable while out_valid && !out_ready.
- Ordering: strictly in order; no drop, no duplication.
- The MSB carry-out is discarded unless FINAL_ADDER_COUT_EN is defined.
- in_valid && !in_ready: the upstream holds its data; the block does not sample it.
- Simultaneous out_ready and in_valid on a full pipe: the output retires and the input enters on the same edge, so full throughput is kept.
- STAGES=1 (CHUNK=WIDTH) is legal: a single registered adder with latency 1.

Optional Feature:
- Macro FINAL_ADDER_COUT_EN.
- Defined:
  - Extra port out_cout, output, 1 bit: the carry out of bit WIDTH-1.
  - It is registered in the final stage, aligned with out_result, and follows the same stall and reset rules (reset value 0).
- Undefined:
  - Port absent; the final-stage carry-out is dropped and no register is inferred for it.

Test Plan:
- Cross-slice carry (WIDTH=16, CHUNK=8): in_sum=0x00FF, in_carry=0x0001, out_ready=1 -> out_result=0x0100, out_valid exactly 2 cycles after accept, pulse width 1.
- Wrap: 0xFFFF + 0x0001 -> out_result=0x0000; with FINAL_ADDER_COUT_EN, out_cout=1. Then 0x1234 + 0x4321 -> 0x5555, out_cout=0.
- Back-to-back: 3 consecutive accepts (0x0001+0x0001, 0x00F0+0x0010, 0x7FFF+0x0001) -> results 0x0002, 0x0100, 0x8000 on 3 consecutive cycles, in order.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_result unchanged, in_ready=0, upstream pair held. On release all results emerge in order, none lost.
- Reset mid-flight: assert rst asynchronously (between edges) with 2 transactions in the pipe -> out_valid=0 and out_result=0 immediately. After deassert, the next pair 0x0003+0x0004 yields 0x0007 with normal latency.
- Random regression: 10k random pairs with random out_ready/in_valid gaps (CHUNK=4 and CHUNK=16 builds) -> every result equals (a+b) mod 2^16 versus a scoreboard model, in order.

Source files
------------

// File: rtl/wallace_final_adder.sv
// wallace_final_adder: pipelined carry-propagate adder that turns the sum/carry rows of a Wallace tree into the final product
//   WIDTH-bit rows are added CHUNK bits per stage; the slice carry ripples stage to stage.
//   Ports: clk, rst (async, active high), in_valid/in_ready/in_sum/in_carry (upstream handshake and rows),
//          out_valid/out_ready/out_result (downstream handshake and (in_sum + in_carry) mod 2^WIDTH).
//   Define FINAL_ADDER_COUT_EN to add out_cout, the registered carry out of bit WIDTH-1.
module wallace_final_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef FINAL_ADDER_COUT_EN
  ,
  output logic             out_cout
`endif
);
  localparam int STAGES = WIDTH / CHUNK;
  if (WIDTH % CHUNK != 0) begin : g_bad
    $error("wallace_final_adder: WIDTH must be a multiple of CHUNK");
  end
  logic             advance;
  logic             v  [STAGES];
  logic             nv [STAGES];
  logic             qc [STAGES];
  logic             nc [STAGES];
  logic [WIDTH-1:0] qa [STAGES];
  logic [WIDTH-1:0] qb [STAGES];
  logic [WIDTH-1:0] qr [STAGES];
  logic [WIDTH-1:0] na [STAGES];
  logic [WIDTH-1:0] nb [STAGES];
  logic [WIDTH-1:0] nr [STAGES];
  // the whole pipe moves or freezes together, so the only stall source is the output register
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic [WIDTH-1:0] ia, ib, ir;
    logic             ic;
    logic [CHUNK:0]   sum;
    if (s == 0) begin : g_head
      assign ia    = in_sum;
      assign ib    = in_carry;
      assign ir    = '0;
      assign ic    = 1'b0;
      assign nv[s] = in_valid;
    end else begin : g_tail
      assign ia    = qa[s-1];
      assign ib    = qb[s-1];
      assign ir    = qr[s-1];
      assign ic    = qc[s-1];
      assign nv[s] = v[s-1];
    end
    assign sum   = {1'b0, ia[s*CHUNK +: CHUNK]} + {1'b0, ib[s*CHUNK +: CHUNK]} + (CHUNK+1)'(ic);
    assign na[s] = ia;
    assign nb[s] = ib;
    assign nc[s] = sum[CHUNK];
    // splice this stage's slice into the result accumulated by the stages below
    assign nr[s] = (ir & ~(WIDTH'({CHUNK{1'b1}}) << (s*CHUNK))) | (WIDTH'(sum[CHUNK-1:0]) << (s*CHUNK));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v  <= '{default: 1'b0};
      qc <= '{default: 1'b0};
      qa <= '{default: '0};
      qb <= '{default: '0};
      qr <= '{default: '0};
    end else if (advance) begin
      v  <= nv;
      qc <= nc;
      qa <= na;
      qb <= nb;
      qr <= nr;
    end
  assign out_valid  = v[STAGES-1];
  assign out_result = qr[STAGES-1];
`ifdef FINAL_ADDER_COUT_EN
  assign out_cout   = qc[STAGES-1];
`endif
endmodule
